// File: rtl/vga_scan_gen.sv
// vga_scan_gen: parametrised VGA raster generator; drives hs/vs, frame-buffer read address and registered RGB.
// Latency: counter state reaches hs/vs/de/frame_tick/r/g/b RD_LAT+1 cycles later; addresses are combinational.
// Backpressure: none, free-running at the pixel clock; din must be valid RD_LAT cycles after its address.
// Ports: vga_clk pixel clock, clr sync active-high reset, din {r,g,b} pixel from frame buffer,
//        col_addr/row_addr frame-buffer address, hs/vs sync, r/g/b colour, de active video,
//        frame_tick one-cycle pulse on pixel (0,0) aligned with r/g/b.
module vga_scan_gen #(
   parameter int H_ACTIVE    = 640,
   parameter int H_FP        = 16,
   parameter int H_SYNC      = 96,
   parameter int H_BP        = 48,
   parameter int V_ACTIVE    = 480,
   parameter int V_FP        = 10,
   parameter int V_SYNC      = 2,
   parameter int V_BP        = 33,
   parameter bit HS_POL      = 1'b0,
   parameter bit VS_POL      = 1'b0,
   parameter int SCALE_SHIFT = 3,
   parameter int COL_W       = 7,
   parameter int ROW_W       = 6,
   parameter int RD_LAT      = 1
) (
   input  logic             vga_clk,
   input  logic             clr,
   input  logic [11:0]      din,
   output logic [COL_W-1:0] col_addr,
   output logic [ROW_W-1:0] row_addr,
   output logic             hs,
   output logic             vs,
   output logic [3:0]       r,
   output logic [3:0]       g,
   output logic [3:0]       b,
   output logic             de,
   output logic             frame_tick
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   // One spare code so a sync end equal to the total never wraps to zero.
   localparam int HW = $clog2(H_TOTAL + 1);
   localparam int VW = $clog2(V_TOTAL + 1);
   localparam int NS = RD_LAT + 1;

   localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACTEND = HW'(H_ACTIVE);
   localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACTEND = VW'(V_ACTIVE);
   localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

   // Bit positions inside one pipeline stage.
   localparam int F_DE = 0;
   localparam int F_HS = 1;
   localparam int F_VS = 2;
   localparam int F_FT = 3;

   logic [HW-1:0] r_hcnt;
   logic [VW-1:0] r_vcnt;
   logic [3:0]    r_flags [NS];
   logic [11:0]   r_rgb;

   logic          w_h_act;
   logic          w_v_act;
   logic          w_de;
   logic          w_hs_on;
   logic          w_vs_on;
   logic          w_first;
   logic [3:0]    w_raw;
   logic          w_rgb_ld;

   // ---------------- raster counters ----------------
   always_ff @(posedge vga_clk) begin
      if (clr) begin
         r_hcnt <= '0;
         r_vcnt <= '0;
      end else if (r_hcnt == H_LAST) begin
         r_hcnt <= '0;
         r_vcnt <= (r_vcnt == V_LAST) ? '0 : r_vcnt + 1'b1;
      end else begin
         r_hcnt <= r_hcnt + 1'b1;
      end
   end

   // ---------------- raw decode ----------------
   // Sync flags are kept active-high internally; polarity is applied at the outputs
   // so that cleared pipeline stages always mean "sync inactive".
   assign w_h_act = (r_hcnt < H_ACTEND);
   assign w_v_act = (r_vcnt < V_ACTEND);
   assign w_de    = w_h_act && w_v_act;
   assign w_hs_on = (r_hcnt >= HS_BEG) && (r_hcnt < HS_END);
   assign w_vs_on = (r_vcnt >= VS_BEG) && (r_vcnt < VS_END);
   assign w_first = (r_hcnt == '0) && (r_vcnt == '0);
   assign w_raw   = {w_first, w_vs_on, w_hs_on, w_de};

   // Address is forced to 0 outside the active window so the frame buffer
   // sees a stable read during blanking.
   assign col_addr = w_de ? COL_W'(r_hcnt >> SCALE_SHIFT) : '0;
   assign row_addr = w_de ? ROW_W'(r_vcnt >> SCALE_SHIFT) : '0;

   // ---------------- flag pipeline ----------------
   // Stage k holds the decode of the counter state k+1 cycles ago.
   always_ff @(posedge vga_clk) begin
      if (clr) begin
         for (int k = 0; k < NS; k++) begin
            r_flags[k] <= '0;
         end
      end else begin
         r_flags[0] <= w_raw;
         for (int k = 1; k < NS; k++) begin
            r_flags[k] <= r_flags[k-1];
         end
      end
   end

   // The de value that belongs to the pixel currently on din: the raw decode
   // when the memory is combinational, otherwise the stage RD_LAT-1 deep.
   if (RD_LAT == 0) begin : g_ld_raw
      assign w_rgb_ld = w_de;
   end else begin : g_ld_pipe
      assign w_rgb_ld = r_flags[RD_LAT-1][F_DE];
   end

   // ---------------- RGB register ----------------
   always_ff @(posedge vga_clk) begin
      if (clr) begin
         r_rgb <= '0;
      end else begin
         r_rgb <= w_rgb_ld ? din : 12'h000;
      end
   end

   // ---------------- outputs ----------------
   assign de         = r_flags[NS-1][F_DE];
   assign frame_tick = r_flags[NS-1][F_FT];
   assign hs         = HS_POL ? r_flags[NS-1][F_HS] : ~r_flags[NS-1][F_HS];
   assign vs         = VS_POL ? r_flags[NS-1][F_VS] : ~r_flags[NS-1][F_VS];
   assign r          = r_rgb[11:8];
   assign g          = r_rgb[7:4];
   assign b          = r_rgb[3:0];

endmodule

// File: tb/tb_vga_scan_gen.sv
// tb_vga_scan_gen: directed bench for vga_scan_gen covering default timing, scaling, latency sweep,
// mid-frame reset and sync polarity.
// Latency/backpressure: not applicable (testbench).
module tb_vga_scan_gen;

   logic vga_clk = 1'b0;
   always #5 vga_clk = ~vga_clk;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // ---------------- default-parameter instance (RD_LAT = 1) ----------------
   logic        clr_d;
   logic [11:0] din_d;
   logic [6:0]  col_d;
   logic [5:0]  row_d;
   logic        hs_d, vs_d, de_d, ft_d;
   logic [3:0]  r_d, g_d, b_d;

   vga_scan_gen u_def (
      .vga_clk(vga_clk), .clr(clr_d), .din(din_d),
      .col_addr(col_d), .row_addr(row_d), .hs(hs_d), .vs(vs_d),
      .r(r_d), .g(g_d), .b(b_d), .de(de_d), .frame_tick(ft_d)
   );

   // ---------------- small-timing instances, RD_LAT = 0..3 ----------------
   // H 16/2/3/3 (total 24), V 8/1/2/1 (total 12), SCALE_SHIFT 1.
   logic        clr_s;
   logic [2:0]  s_col [4];
   logic [1:0]  s_row [4];
   logic        s_hs [4];
   logic        s_vs [4];
   logic        s_de [4];
   logic        s_ft [4];
   logic [3:0]  s_r [4];
   logic [3:0]  s_g [4];
   logic [3:0]  s_b [4];
   logic [11:0] s_din [4];

   for (genvar gi = 0; gi < 4; gi++) begin : g_lat
      logic [11:0] mem_q [4];
      logic [11:0] pix;
      assign pix = {2'b00, s_row[gi], 1'b0, s_col[gi], 4'hA};
      // Frame-buffer model: returns the pixel RD_LAT cycles after its address.
      always @(posedge vga_clk) begin
         mem_q[0] <= pix;
         for (int k = 1; k < 4; k++) mem_q[k] <= mem_q[k-1];
      end
      if (gi == 0) begin : g_comb
         assign s_din[gi] = pix;
      end else begin : g_reg
         assign s_din[gi] = mem_q[gi-1];
      end

      vga_scan_gen #(
         .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
         .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
         .SCALE_SHIFT(1), .COL_W(3), .ROW_W(2), .RD_LAT(gi)
      ) u_small (
         .vga_clk(vga_clk), .clr(clr_s), .din(s_din[gi]),
         .col_addr(s_col[gi]), .row_addr(s_row[gi]), .hs(s_hs[gi]), .vs(s_vs[gi]),
         .r(s_r[gi]), .g(s_g[gi]), .b(s_b[gi]), .de(s_de[gi]), .frame_tick(s_ft[gi])
      );
   end

   // ---------------- polarity instance: active-high syncs, RD_LAT = 1 ----------------
   logic [11:0] din_p;
   logic [2:0]  col_p;
   logic [1:0]  row_p;
   logic        hs_p, vs_p, de_p, ft_p;
   logic [3:0]  r_p, g_p, b_p;

   vga_scan_gen #(
      .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .HS_POL(1'b1), .VS_POL(1'b1),
      .SCALE_SHIFT(1), .COL_W(3), .ROW_W(2), .RD_LAT(1)
   ) u_pol (
      .vga_clk(vga_clk), .clr(clr_s), .din(din_p),
      .col_addr(col_p), .row_addr(row_p), .hs(hs_p), .vs(vs_p),
      .r(r_p), .g(g_p), .b(b_p), .de(de_p), .frame_tick(ft_p)
   );

   // ---------------- reference model for the small timing ----------------
   int mh = 0, mv = 0;           // counter state of the current cycle
   int hh [4];                   // hh[k]/hv[k]: counter state k+1 cycles ago
   int hv [4];
   bit hvld [4] = '{default: 1'b0};

   function automatic bit sde(input int h, input int v);
      return (h < 16) && (v < 8);
   endfunction
   function automatic bit shs(input int h);
      return (h >= 18) && (h < 21);
   endfunction
   function automatic bit svs(input int v);
      return (v >= 9) && (v < 11);
   endfunction
   function automatic logic [11:0] spix(input int h, input int v);
      return {4'(v >> 1), 4'(h >> 1), 4'hA};
   endfunction

   task automatic check_small();
      logic [31:0] e_de, e_hs, e_vs, e_ft, e_rgb, e_col, e_row;
      e_col = sde(mh, mv) ? 32'(mh >> 1) : 32'd0;
      e_row = sde(mh, mv) ? 32'(mv >> 1) : 32'd0;
      for (int i = 0; i < 4; i++) begin
         if (hvld[i]) begin
            e_de  = 32'(sde(hh[i], hv[i]));
            e_hs  = 32'(!shs(hh[i]));
            e_vs  = 32'(!svs(hv[i]));
            e_ft  = 32'((hh[i] == 0) && (hv[i] == 0));
            e_rgb = e_de[0] ? 32'(spix(hh[i], hv[i])) : 32'd0;
         end else begin
            e_de = 0; e_hs = 1; e_vs = 1; e_ft = 0; e_rgb = 0;
         end
         chk($sformatf("lat%0d.de", i), 32'(s_de[i]), e_de);
         chk($sformatf("lat%0d.hs", i), 32'(s_hs[i]), e_hs);
         chk($sformatf("lat%0d.vs", i), 32'(s_vs[i]), e_vs);
         chk($sformatf("lat%0d.frame_tick", i), 32'(s_ft[i]), e_ft);
         chk($sformatf("lat%0d.rgb", i), 32'({s_r[i], s_g[i], s_b[i]}), e_rgb);
         chk($sformatf("lat%0d.col_addr", i), 32'(s_col[i]), e_col);
         chk($sformatf("lat%0d.row_addr", i), 32'(s_row[i]), e_row);
      end
      // Polarity instance has RD_LAT = 1 and active-high syncs.
      if (hvld[1]) begin
         e_de  = 32'(sde(hh[1], hv[1]));
         e_hs  = 32'(shs(hh[1]));
         e_vs  = 32'(svs(hv[1]));
         e_rgb = e_de[0] ? 32'h3C5 : 32'd0;
      end else begin
         e_de = 0; e_hs = 0; e_vs = 0; e_rgb = 0;
      end
      chk("pol.hs", 32'(hs_p), e_hs);
      chk("pol.vs", 32'(vs_p), e_vs);
      chk("pol.de", 32'(de_p), e_de);
      chk("pol.rgb", 32'({r_p, g_p, b_p}), e_rgb);
   endtask

   // One clock: advance the model at the rising edge, check at the falling edge.
   task automatic step_small();
      @(posedge vga_clk);
      if (clr_s) begin
         for (int k = 0; k < 4; k++) hvld[k] = 1'b0;
         mh = 0;
         mv = 0;
      end else begin
         for (int k = 3; k > 0; k--) begin
            hh[k] = hh[k-1]; hv[k] = hv[k-1]; hvld[k] = hvld[k-1];
         end
         hh[0] = mh; hv[0] = mv; hvld[0] = 1'b1;
         if (mh == 23) begin
            mh = 0;
            mv = (mv == 11) ? 0 : mv + 1;
         end else begin
            mh = mh + 1;
         end
      end
      @(negedge vga_clk);
      check_small();
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int de_cnt, hs_lo, vs_lo, ft_cnt, col_nz, col_max, row_max;
      int fall1, fall2, last_ft, n;
      logic hs_prev;

      clr_d = 1'b1;
      clr_s = 1'b1;
      din_d = 12'h5A3;
      din_p = 12'h3C5;

      // Reset held for three edges.
      @(negedge vga_clk);
      repeat (3) step_small();
      chk("def.rst_hs", 32'(hs_d), 32'd1);
      chk("def.rst_vs", 32'(vs_d), 32'd1);
      chk("def.rst_de", 32'(de_d), 32'd0);
      chk("def.rst_rgb", 32'({r_d, g_d, b_d}), 32'd0);
      chk("def.rst_ft", 32'(ft_d), 32'd0);
      chk("def.rst_col", 32'(col_d), 32'd0);
      chk("def.rst_row", 32'(row_d), 32'd0);

      // Release: first de/frame_tick two edges later on the default instance.
      clr_d = 1'b0;
      clr_s = 1'b0;
      step_small();
      chk("def.rel1_de", 32'(de_d), 32'd0);
      chk("def.rel1_ft", 32'(ft_d), 32'd0);
      step_small();
      chk("def.rel2_de", 32'(de_d), 32'd1);
      chk("def.rel2_ft", 32'(ft_d), 32'd1);
      chk("def.rel2_rgb", 32'({r_d, g_d, b_d}), 32'h5A3);
      chk("def.rel2_hs", 32'(hs_d), 32'd1);

      // Three default lines measured from the first active output pixel.
      de_cnt = 0; hs_lo = 0; vs_lo = 0; ft_cnt = 0; col_nz = 0; col_max = 0; row_max = 0;
      fall1 = -1; fall2 = -1; last_ft = -1; hs_prev = 1'b1;
      for (int off = 0; off < 2400; off++) begin
         if (off != 0) step_small();
         if (de_d === 1'b1) de_cnt++;
         if (hs_d === 1'b0) hs_lo++;
         if (vs_d === 1'b0) vs_lo++;
         if (ft_d === 1'b1) ft_cnt++;
         if (hs_prev === 1'b1 && hs_d === 1'b0) begin
            if (fall1 < 0) fall1 = off;
            else if (fall2 < 0) fall2 = off;
         end
         hs_prev = hs_d;
         if (col_d != 0) col_nz++;
         if (int'(col_d) > col_max) col_max = int'(col_d);
         if (int'(row_d) > row_max) row_max = int'(row_d);
         if (s_ft[0] === 1'b1) begin
            if (last_ft >= 0) chk("lat0.ft_period", 32'(off - last_ft), 32'd288);
            last_ft = off;
         end
      end
      chk("def.de_cycles_3lines", 32'(de_cnt), 32'd1920);
      chk("def.hs_low_3lines", 32'(hs_lo), 32'd288);
      chk("def.vs_low_3lines", 32'(vs_lo), 32'd0);
      chk("def.ft_count", 32'(ft_cnt), 32'd1);
      chk("def.hs_fall1", 32'(fall1), 32'd656);
      chk("def.hs_period", 32'(fall2 - fall1), 32'd800);
      chk("def.col_nonzero", 32'(col_nz), 32'd1896);
      chk("def.col_max", 32'(col_max), 32'd79);
      chk("def.row_max", 32'(row_max), 32'd0);

      // Mid-line reset on the default instance while showing a lit pixel.
      n = 0;
      while (de_d !== 1'b1 && n < 1000) begin
         step_small();
         n++;
      end
      chk("def.wait_de", 32'(de_d), 32'd1);
      repeat (300) step_small();
      chk("def.pre_rst_rgb", 32'({r_d, g_d, b_d}), 32'h5A3);
      clr_d = 1'b1;
      step_small();
      clr_d = 1'b0;
      chk("def.mid_hs", 32'(hs_d), 32'd1);
      chk("def.mid_vs", 32'(vs_d), 32'd1);
      chk("def.mid_de", 32'(de_d), 32'd0);
      chk("def.mid_col", 32'(col_d), 32'd0);
      chk("def.mid_row", 32'(row_d), 32'd0);
      chk("def.mid_rgb", 32'({r_d, g_d, b_d}), 32'd0);
      chk("def.mid_ft", 32'(ft_d), 32'd0);
      step_small();
      chk("def.mid1_de", 32'(de_d), 32'd0);
      chk("def.mid1_rgb", 32'({r_d, g_d, b_d}), 32'd0);
      step_small();
      chk("def.mid2_de", 32'(de_d), 32'd1);
      chk("def.mid2_ft", 32'(ft_d), 32'd1);
      chk("def.mid2_rgb", 32'({r_d, g_d, b_d}), 32'h5A3);

      // Mid-frame reset of the small instances at hcnt 10, vcnt 5.
      n = 0;
      while (!(mh == 10 && mv == 5) && n < 400) begin
         step_small();
         n++;
      end
      chk("small.wait_pos", 32'((mh == 10) && (mv == 5)), 32'd1);
      clr_s = 1'b1;
      step_small();
      clr_s = 1'b0;
      chk("lat3.mid_de", 32'(s_de[3]), 32'd0);
      chk("lat3.mid_rgb", 32'({s_r[3], s_g[3], s_b[3]}), 32'd0);
      chk("lat0.mid_col", 32'(s_col[0]), 32'd0);
      repeat (320) step_small();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
